// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue
//   Issue stage in front of a combinational RISCVALU. Takes one decoded op per valid/ready
//   handshake and maps ALUOp/funct3/funct7[5] to a 4-bit ALUctl. It registers ALUctl/A/B onto
//   the ALU, waits ALU_LATENCY cycles, then captures ALUout/Zero and offers them on a
//   valid/ready result port. Ops with no ALUctl mapping skip the ALU and return out_illegal=1.
//
// Parameters
//   XLEN         operand/result width, must match the ALU
//   ALU_LATENCY  cycles ALU inputs are held before ALUout/Zero are sampled (1..15)
//
// Ports
//   clock, reset                  single clock, synchronous active-high reset
//   in_valid/in_ready             request handshake; in_ready is high only while idle
//   in_aluop, in_funct3,
//   in_funct7b5, in_a, in_b       decoded op and operands
//   alu_ctl, alu_a, alu_b         registered drive to RISCVALU.ALUctl/A/B
//   alu_out, alu_zero             RISCVALU.ALUout/Zero
//   out_valid/out_ready           result handshake, unbounded backpressure
//   out_result, out_zero,
//   out_illegal                   captured result (result/zero forced to 0 for illegal ops)
//
// Build option
//   ALU_ISSUE_STATS_EN  adds stat_ops / stat_illegal: saturating 32-bit counts of returned
//                       legal / illegal results, bumped on the result handshake edge.

module riscv_alu_issue #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [3:0]      alu_ctl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]     stat_ops,
    output logic [31:0]     stat_illegal,
`endif
    output logic            out_illegal
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    // Counter reload: the capture happens on the edge where the count has reached zero.
    localparam logic [3:0] CntInit = 4'(ALU_LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        ctl_q, ctl_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              zero_q, zero_d;
    logic              ill_q, ill_d;

    logic [3:0]        dec_ctl;
    logic              dec_legal;

    // ALUctl decode
    always_comb begin
        dec_ctl   = 4'b0000;
        dec_legal = 1'b1;
        case (in_aluop)
            2'b00: dec_ctl = 4'b0010;
            2'b01: dec_ctl = 4'b0110;
            2'b10: begin
                case (in_funct3)
                    3'b000:  dec_ctl = in_funct7b5 ? 4'b0110 : 4'b0010;
                    3'b111:  dec_ctl = 4'b0000;
                    3'b110:  dec_ctl = 4'b0001;
                    3'b010:  dec_ctl = 4'b0111;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctl_d     = ctl_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        zero_d    = zero_q;
        ill_d     = ill_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (dec_legal) begin
                        ctl_d   = dec_ctl;
                        a_d     = in_a;
                        b_d     = in_b;
                        cnt_d   = CntInit;
                        state_d = StExec;
                    end else begin
                        // ALU drive is left untouched; the result is synthesised here.
                        res_d   = '0;
                        zero_d  = 1'b0;
                        ill_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_out;
                    zero_d  = alu_zero;
                    ill_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ctl_q   <= 4'b0000;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_ctl     = ctl_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_illegal = ill_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] ops_q, ops_d;
    logic [31:0] illc_q, illc_d;
    logic        out_hs;

    assign out_hs = out_valid & out_ready;

    always_comb begin
        ops_d  = ops_q;
        illc_d = illc_q;
        if (out_hs) begin
            if (ill_q) begin
                if (illc_q != 32'hFFFF_FFFF) illc_d = illc_q + 32'd1;
            end else begin
                if (ops_q != 32'hFFFF_FFFF) ops_d = ops_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ops_q  <= 32'd0;
            illc_q <= 32'd0;
        end else begin
            ops_q  <= ops_d;
            illc_q <= illc_d;
        end
    end

    assign stat_ops     = ops_q;
    assign stat_illegal = illc_q;
`endif

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed bench for riscv_alu_issue. Two instances share clock/reset and request fields:
// dut1 uses ALU_LATENCY=1, dut3 uses ALU_LATENCY=3. A small RISCVALU model sits behind each.
// Expected results are queued when a request is driven and checked when the result handshakes.

module tb_riscv_alu_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  in_aluop = 2'b00;
    logic [2:0]  in_funct3 = 3'b000;
    logic        in_funct7b5 = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic        in_ready1, out_valid1, alu_zero1, out_zero1, out_illegal1;
    logic [3:0]  alu_ctl1;
    logic [63:0] alu_a1, alu_b1, alu_out1, out_result1;

    logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
    logic        in_ready3, out_valid3, alu_zero3, out_zero3, out_illegal3;
    logic [3:0]  alu_ctl3;
    logic [63:0] alu_a3, alu_b3, alu_out3, out_result3;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops1, stat_illegal1, stat_ops3, stat_illegal3;
`endif

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb1[$];
    exp_t sb3[$];

    int tests = 0;
    int fails = 0;
    int hs1 = 0;
    int hs3 = 0;

    logic [3:0]  last_ctl = 4'b0000;
    logic [63:0] last_a = '0, last_b = '0;

    always #5 clock = ~clock;

    riscv_alu_issue #(.XLEN(64), .ALU_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_aluop(in_aluop), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_a(in_a), .in_b(in_b),
        .alu_ctl(alu_ctl1), .alu_a(alu_a1), .alu_b(alu_b1),
        .alu_out(alu_out1), .alu_zero(alu_zero1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_zero(out_zero1),
`ifdef ALU_ISSUE_STATS_EN
        .stat_ops(stat_ops1), .stat_illegal(stat_illegal1),
`endif
        .out_illegal(out_illegal1)
    );

    riscv_alu_issue #(.XLEN(64), .ALU_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_aluop(in_aluop), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_a(in_a), .in_b(in_b),
        .alu_ctl(alu_ctl3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_out(alu_out3), .alu_zero(alu_zero3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_result(out_result3), .out_zero(out_zero3),
`ifdef ALU_ISSUE_STATS_EN
        .stat_ops(stat_ops3), .stat_illegal(stat_illegal3),
`endif
        .out_illegal(out_illegal3)
    );

    // Combinational RISCVALU model
    function automatic logic [63:0] alu_f(input logic [3:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    assign alu_out1  = alu_f(alu_ctl1, alu_a1, alu_b1);
    assign alu_zero1 = (alu_out1 == 64'd0);
    assign alu_out3  = alu_f(alu_ctl3, alu_a3, alu_b3);
    assign alu_zero3 = (alu_out3 == 64'd0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result scoreboards: a handshake happens on the posedge after a negedge with valid&ready.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid1 && out_ready1) begin
            hs1++;
            tests++;
            assert (sb1.size() > 0) else begin
                fails++;
                $error("FAIL sb1_pending: got 0 queued expected >=1");
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                chk("sb1_result", out_result1, e.res);
                chk("sb1_zero", out_zero1, e.zero);
                chk("sb1_illegal", out_illegal1, e.ill);
            end
        end
        if (!reset && out_valid3 && out_ready3) begin
            hs3++;
            tests++;
            assert (sb3.size() > 0) else begin
                fails++;
                $error("FAIL sb3_pending: got 0 queued expected >=1");
            end
            if (sb3.size() > 0) begin
                e = sb3.pop_front();
                chk("sb3_result", out_result3, e.res);
                chk("sb3_zero", out_zero3, e.zero);
                chk("sb3_illegal", out_illegal3, e.ill);
            end
        end
    end

    // One op through dut1 (latency 1, out_ready tied high).
    task automatic op1(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic b5, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] ectl, input logic [63:0] eres, input logic ezero,
                       input logic eill);
        int n;
        chk({tag, "_in_ready_idle"}, in_ready1, 1);
        in_aluop    = op;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_a        = a;
        in_b        = b;
        in_valid1   = 1'b1;
        sb1.push_back('{res: eres, zero: ezero, ill: eill});
        @(posedge clock); #1;
        in_valid1 = 1'b0;
        if (!eill) begin
            last_ctl = ectl;
            last_a   = a;
            last_b   = b;
        end
        chk({tag, "_in_ready_busy"}, in_ready1, 0);
        chk({tag, "_alu_ctl"}, alu_ctl1, last_ctl);
        chk({tag, "_alu_a"}, alu_a1, last_a);
        chk({tag, "_alu_b"}, alu_b1, last_b);
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_latency"}, n, eill ? 0 : 1);
        @(posedge clock); #1;
        chk({tag, "_valid_drop"}, out_valid1, 0);
        chk({tag, "_back_idle"}, in_ready1, 1);
        chk({tag, "_result_held"}, out_result1, eres);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_alu_ctl", alu_ctl1, 0);
        chk("rst_alu_a", alu_a1, 0);
        chk("rst_alu_b", alu_b1, 0);
        chk("rst_out_result", out_result1, 0);
        chk("rst_out_zero", out_zero1, 0);
        chk("rst_out_illegal", out_illegal1, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        op1("add",   2'b10, 3'b000, 1'b0, 64'd1560, 64'd3,    4'b0010, 64'd1563, 1'b0, 1'b0);
        op1("subz",  2'b01, 3'b101, 1'b0, 64'd3,    64'd3,    4'b0110, 64'd0,    1'b1, 1'b0);
        op1("slt",   2'b10, 3'b010, 1'b0, 64'd3,    64'd1560, 4'b0111, 64'd1,    1'b0, 1'b0);
        op1("and",   2'b10, 3'b111, 1'b0, 64'd3,    64'd1560, 4'b0000, 64'd0,    1'b1, 1'b0);
        op1("or",    2'b10, 3'b110, 1'b0, 64'd3,    64'd1560, 4'b0001, 64'd1563, 1'b0, 1'b0);
        op1("ldst",  2'b00, 3'b011, 1'b1, 64'd100,  64'd28,   4'b0010, 64'd128,  1'b0, 1'b0);
        op1("rsub",  2'b10, 3'b000, 1'b1, 64'd10,   64'd4,    4'b0110, 64'd6,    1'b0, 1'b0);
        op1("ill1",  2'b10, 3'b001, 1'b0, 64'd7,    64'd9,    4'b0000, 64'd0,    1'b0, 1'b1);
        op1("ill3",  2'b11, 3'b000, 1'b0, 64'd7,    64'd9,    4'b0000, 64'd0,    1'b0, 1'b1);
        op1("after", 2'b10, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
            4'b0010, 64'd0, 1'b1, 1'b0);

        // Latency 3 with five cycles of backpressure once the result is up
        in_aluop    = 2'b10;
        in_funct3   = 3'b000;
        in_funct7b5 = 1'b0;
        in_a        = 64'd5;
        in_b        = 64'd7;
        in_valid3   = 1'b1;
        out_ready3  = 1'b0;
        sb3.push_back('{res: 64'd12, zero: 1'b0, ill: 1'b0});
        @(posedge clock); #1;
        in_valid3 = 1'b0;
        chk("l3_alu_ctl", alu_ctl3, 4'b0010);
        n = 0;
        while (!out_valid3 && n < 20) begin
            chk("l3_in_ready_exec", in_ready3, 0);
            @(posedge clock); #1;
            n++;
        end
        chk("l3_latency", n, 3);
        repeat (5) begin
            @(posedge clock); #1;
            chk("l3_bp_valid", out_valid3, 1);
            chk("l3_bp_result", out_result3, 64'd12);
            chk("l3_bp_in_ready", in_ready3, 0);
        end
        chk("l3_no_early_hs", hs3, 0);
        out_ready3 = 1'b1;
        @(posedge clock); #1;
        out_ready3 = 1'b0;
        chk("l3_one_hs", hs3, 1);
        chk("l3_valid_drop", out_valid3, 0);
        chk("l3_back_idle", in_ready3, 1);

        // Reset while in EXEC discards the op
        in_aluop  = 2'b01;
        in_a      = 64'd9;
        in_b      = 64'd9;
        in_valid3 = 1'b1;
        @(posedge clock); #1;
        in_valid3 = 1'b0;
        chk("rx_in_exec", in_ready3, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        last_ctl = 4'b0000;
        last_a   = '0;
        last_b   = '0;
        chk("rx_in_ready", in_ready3, 1);
        chk("rx_out_valid", out_valid3, 0);
        chk("rx_alu_ctl", alu_ctl3, 0);
        chk("rx_alu_a", alu_a3, 0);
        out_ready3 = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        chk("rx_no_result", out_valid3, 0);
        chk("rx_hs_count", hs3, 1);

        op1("post_rst", 2'b10, 3'b000, 1'b0, 64'd2, 64'd2, 4'b0010, 64'd4, 1'b0, 1'b0);

`ifdef ALU_ISSUE_STATS_EN
        chk("stat_ops1", stat_ops1, 1);
        chk("stat_illegal1", stat_illegal1, 0);
        chk("stat_ops3", stat_ops3, 0);
        chk("stat_illegal3", stat_illegal3, 0);
`endif
        chk("sb1_drained", sb1.size(), 0);
        chk("sb3_drained", sb3.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
